// File: rtl/srl_fifo_pkg.sv
// Shared constants and helpers for the shift-register FIFO.
package srl_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // Level counts storage entries plus the output register, so 0..DEPTH+1.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/srl_fifo_store.sv
// Shift-register storage with an asynchronous read port; no reset, so it maps onto SRL primitives.
module srl_fifo_store #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] srl_q [DEPTH];

  always_ff @(posedge clock) begin
    if (shift_en_i) begin
      srl_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  assign data_o = srl_q[addr_i];

endmodule

// File: rtl/srl_fifo.sv
// FIFO built from shift storage plus a registered output stage; holds DEPTH+1 words.
module srl_fifo
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [WIDTH-1:0]              s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [WIDTH-1:0]              m_tdata,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [LW-1:0]    level_q, level_d;

  logic             wr, rd, load, bypass, stor_load, shift_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] stor_data;

  // Ready depends only on registered count: no combinational path from m_tready.
  assign s_tready = (count_q != CW'(DEPTH));
  assign wr       = s_tvalid && s_tready;
  assign rd       = m_tvalid_q && m_tready;
  assign load     = (!m_tvalid_q || m_tready) && ((count_q != '0) || wr);
  assign bypass   = load && (count_q == '0);
  assign stor_load = load && !bypass;
  assign shift_en = wr && !bypass;
  assign rd_addr  = AW'(count_q - CW'(1));

  srl_fifo_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clock      (clock),
    .shift_en_i (shift_en),
    .data_i     (s_tdata),
    .addr_i     (rd_addr),
    .data_o     (stor_data)
  );

  always_comb begin
    count_d    = count_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    case ({shift_en, stor_load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bypass) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata;
    end else if (stor_load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = stor_data;
    end else if (rd) begin
      m_tvalid_d = 1'b0;
    end
    level_d = LW'(count_d) + LW'(m_tvalid_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      m_tvalid_q <= 1'b0;
      level_q    <= '0;
    end else begin
      count_q    <= count_d;
      m_tvalid_q <= m_tvalid_d;
      level_q    <= level_d;
    end
  end

  // Output data carries no reset; it is ignored while m_tvalid is low.
  always_ff @(posedge clock) begin
    m_tdata_q <= m_tdata_d;
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign level_o  = level_q;

endmodule

// File: tb/tb_srl_fifo.sv
// Scoreboard bench for srl_fifo: directed scenarios plus a randomized backpressure run.
module tb_srl_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] s_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [WIDTH-1:0] m_tdata;
  logic [4:0]       level_o;

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  srl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .level_o  (level_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, pops on read handshakes, pushes on accepted writes.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_tvalid), 1);
        chk("stall_data", int'(m_tdata), int'(prev_data));
      end
      if (m_tvalid && m_tready) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          chk("read_with_empty_scoreboard", int'(m_tdata), -1);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk("read_data", int'(m_tdata), int'(e));
          $display("read  data=%02h expected=%02h", m_tdata, e);
        end
      end
      if (s_tvalid && s_tready) begin
        wr_cnt++;
        exp_q.push_back(s_tdata);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base_rd, base_wr, max_level, n;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset_level", int'(level_o), 0);
    chk("reset_mvalid", int'(m_tvalid), 0);
    chk("reset_sready", int'(s_tready), 1);

    // Single word through the empty block.
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 8'hA5;
    step();
    s_tvalid = 1'b0;
    chk("single_mvalid", int'(m_tvalid), 1);
    chk("single_level", int'(level_o), 1);
    step();
    chk("single_level_after", int'(level_o), 0);
    chk("single_mvalid_after", int'(m_tvalid), 0);

    // Fill to DEPTH+1 with the sink stalled.
    m_tready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      chk("fill_sready", int'(s_tready), 1);
      s_tvalid = 1'b1; s_tdata = 8'(i);
      step();
    end
    s_tdata = 8'h11;
    chk("full_sready", int'(s_tready), 0);
    chk("full_level", int'(level_o), DEPTH + 1);
    step();
    chk("refused_level", int'(level_o), DEPTH + 1);
    // Read and blocked write at count == DEPTH.
    m_tready = 1'b1; s_tdata = 8'h55;
    step();
    s_tvalid = 1'b0;
    chk("freed_sready", int'(s_tready), 1);
    chk("freed_level", int'(level_o), DEPTH);
    for (int i = 0; i < DEPTH; i++) step();
    chk("drained_level", int'(level_o), 0);

    // Streaming at full rate.
    base_rd = rd_cnt; base_wr = wr_cnt; max_level = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i + 8'h20);
      step();
      if (int'(level_o) > max_level) max_level = int'(level_o);
    end
    s_tvalid = 1'b0;
    step();
    chk("stream_writes", wr_cnt - base_wr, 100);
    chk("stream_reads", rd_cnt - base_rd, 100);
    chk("stream_max_level", max_level, 1);

    // Random valid/ready at 50%.
    for (int i = 0; i < 10000; i++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      s_tdata  = 8'($urandom);
      step();
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    n = 0;
    while ((level_o != 0 || m_tvalid) && n < 40) begin
      step();
      n++;
    end
    chk("random_drain_level", int'(level_o), 0);
    chk("random_scoreboard_empty", exp_q.size(), 0);

    // Reset in the middle of a stream.
    m_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h80 + i);
      step();
    end
    chk("pre_reset_level", int'(level_o), 9);
    reset = 1'b1; s_tdata = 8'h77; m_tready = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_level", int'(level_o), 0);
    chk("midreset_mvalid", int'(m_tvalid), 0);
    chk("midreset_sready", int'(s_tready), 1);
    s_tvalid = 1'b1; s_tdata = 8'h3C; m_tready = 1'b0;
    step();
    s_tvalid = 1'b0;
    chk("post_reset_mvalid", int'(m_tvalid), 1);
    chk("post_reset_data", int'(m_tdata), 8'h3C);
    chk("post_reset_level", int'(level_o), 1);
    m_tready = 1'b1;
    step();
    chk("post_reset_final_level", int'(level_o), 0);
    step();
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srl_fifo.md
SRL_FIFO -- requirements
Module: srl_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of shift-storage entries; power of two, at least 2.
REQ-003 clock  input  1: the only clock; all state updates on its rising edge.
REQ-004 reset  input  1: reset, synchronous and active-high.
REQ-005 s_tvalid  input  1: upstream word valid.
REQ-006 s_tready  output  1: space available; equals (count != DEPTH).
REQ-007 s_tdata  input  WIDTH: upstream word.
REQ-008 m_tvalid  output  1: output register holds a word; registered.
REQ-009 m_tready  input  1: downstream accepts the word.
REQ-010 m_tdata  output  WIDTH: head word; registered.
REQ-011 level_o  output  clog2(DEPTH+2): words held, equals count + m_tvalid; registered.

Function
REQ-012 A write is accepted when s_tvalid && s_tready; a read completes when m_tvalid && m_tready.
REQ-013 On a write that does not bypass (see REQ-016), the storage shifts: srl[i+1] <= srl[i] for all i, and srl[0] <= s_tdata.
REQ-014 count (0..DEPTH) tracks the occupied storage entries; the oldest entry is srl[count-1], read combinationally.
REQ-015 The output register loads when (!m_tvalid || m_tready) and a word is available.
REQ-016 Bypass: if count == 0 and the output register loads on a write cycle, s_tdata goes directly to m_tdata, storage is untouched, and count is unchanged.
REQ-017 Non-bypass load: m_tdata <= srl[count-1] using the pre-shift address; count decrements unless a write also occurs in the same cycle.
REQ-018 Simultaneous storage read and write: shift and load occur in the same edge; count is unchanged and ordering is preserved.
REQ-019 When no load occurs but m_tready && m_tvalid, m_tvalid <= 0.
REQ-020 Latency: a word written into the empty block appears on m_tvalid/m_tdata 1 cycle after acceptance.
REQ-021 Total capacity is DEPTH+1 words. s_tready deasserts at count == DEPTH even if m_tready is high that cycle; there is no combinational ready path.
REQ-022 m_tdata and m_tvalid are held stable while m_tvalid && !m_tready.
REQ-023 Storage contents outside 0..count-1 are don't-care and shall never reach m_tdata.

Reset
REQ-024 reset clears count to 0, and sets m_tvalid to 0, level_o to 0 and s_tready to 1 on the next edge.
REQ-025 Storage contents and m_tdata are not reset; m_tdata is don't-care while m_tvalid is 0.
REQ-026 reset asserted mid-transfer discards all held words; any write or read presented in that cycle is ignored.

Structure
REQ-027 The default WIDTH/DEPTH constants and the level width function belong in the shared misc package/header; there are no typedefs.
REQ-028 Storage is one natural sub-module, srl_fifo_store, with inputs shift enable and data and an asynchronous read at an address; it contains no reset so it maps to SRL primitives.
REQ-029 Control (count, output register, level) lives in srl_fifo.
REQ-030 Target size is 120-400 lines of RTL in total.

Verification
REQ-031 Single word: write 0xA5 to the empty block with m_tready=1 -> m_tvalid=1 with m_tdata=0xA5 at cycle +1, level_o=1, then 0 after the read.
REQ-032 Fill: m_tready=0, write 0x00..0x10 (17 words) -> s_tready=0 after the 17th, level_o=17, and an 18th write is refused; drain yields 0x00..0x10 in order.
REQ-033 Streaming: s_tvalid=m_tready=1 for 100 cycles with an incrementing payload -> throughput of 1 word per cycle, count stays 0, and the output is in order.
REQ-034 Backpressure: random s_tvalid/m_tready at 50% for 10k cycles -> the output sequence matches a reference queue, and m_tdata is stable whenever stalled.
REQ-035 Simultaneous read and write at count=DEPTH: s_tready=0 so the write is blocked, and the read frees one slot -> s_tready=1 the next cycle.
REQ-036 Reset at level_o=9 mid-stream -> next cycle level_o=0, m_tvalid=0, s_tready=1; a subsequent write of 0x3C is the first word out.
